// File: rtl/inv_substitution_layer_seq.sv
// Multi-cycle inverse Ascon S-box layer: LANES columns of the 5x64 state are inverted per cycle.
// Optional forward-S-box self-check is enabled with the ASCON_INV_SBOX_SELFCHECK_EN macro.

package ascon_pkg;
  // Word 0 (x0) sits in index [0]; each column j is {x0[j],x1[j],x2[j],x3[j],x4[j]}, x0 as MSB.
  typedef logic [4:0][63:0] ascon_state_t;
endpackage

module inv_substitution_layer_seq #(
  parameter int LANES = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  ascon_pkg::ascon_state_t state_array_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output ascon_pkg::ascon_state_t state_array_o,
  output logic                   err_o
);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 ||
          LANES == 16 || LANES == 32 || LANES == 64)) begin : g_bad_lanes
      $error("inv_substitution_layer_seq: LANES must be a power of two from 1 to 64");
    end
  endgenerate

  localparam logic [6:0] LANES_W  = 7'(LANES);
  localparam logic [5:0] LAST_CNT = 6'(64 - LANES);

  function automatic logic [4:0] inv_sbox(input logic [4:0] x);
    logic [4:0] y;
    case (x)
      5'h00: y = 5'h14; 5'h01: y = 5'h1A; 5'h02: y = 5'h07; 5'h03: y = 5'h0D;
      5'h04: y = 5'h00; 5'h05: y = 5'h09; 5'h06: y = 5'h0E; 5'h07: y = 5'h12;
      5'h08: y = 5'h0A; 5'h09: y = 5'h06; 5'h0A: y = 5'h1D; 5'h0B: y = 5'h01;
      5'h0C: y = 5'h19; 5'h0D: y = 5'h15; 5'h0E: y = 5'h13; 5'h0F: y = 5'h1E;
      5'h10: y = 5'h18; 5'h11: y = 5'h16; 5'h12: y = 5'h0B; 5'h13: y = 5'h11;
      5'h14: y = 5'h03; 5'h15: y = 5'h05; 5'h16: y = 5'h1C; 5'h17: y = 5'h1F;
      5'h18: y = 5'h17; 5'h19: y = 5'h1B; 5'h1A: y = 5'h04; 5'h1B: y = 5'h08;
      5'h1C: y = 5'h0F; 5'h1D: y = 5'h0C; 5'h1E: y = 5'h10; default: y = 5'h02;
    endcase
    return y;
  endfunction

`ifdef ASCON_INV_SBOX_SELFCHECK_EN
  function automatic logic [4:0] fwd_sbox(input logic [4:0] x);
    logic [4:0] y;
    case (x)
      5'h00: y = 5'h04; 5'h01: y = 5'h0B; 5'h02: y = 5'h1F; 5'h03: y = 5'h14;
      5'h04: y = 5'h1A; 5'h05: y = 5'h15; 5'h06: y = 5'h09; 5'h07: y = 5'h02;
      5'h08: y = 5'h1B; 5'h09: y = 5'h05; 5'h0A: y = 5'h08; 5'h0B: y = 5'h12;
      5'h0C: y = 5'h1D; 5'h0D: y = 5'h03; 5'h0E: y = 5'h06; 5'h0F: y = 5'h1C;
      5'h10: y = 5'h1E; 5'h11: y = 5'h13; 5'h12: y = 5'h07; 5'h13: y = 5'h0E;
      5'h14: y = 5'h00; 5'h15: y = 5'h0D; 5'h16: y = 5'h11; 5'h17: y = 5'h18;
      5'h18: y = 5'h10; 5'h19: y = 5'h0C; 5'h1A: y = 5'h01; 5'h1B: y = 5'h19;
      5'h1C: y = 5'h16; 5'h1D: y = 5'h0A; 5'h1E: y = 5'h0F; default: y = 5'h17;
    endcase
    return y;
  endfunction
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

  fsm_t                    state_reg, state_next;
  ascon_pkg::ascon_state_t work_reg, work_next;
  logic [5:0]              cnt_reg, cnt_next;

  logic [5:0] col      [LANES];
  logic [4:0] pre_col  [LANES];
  logic [4:0] post_col [LANES];
`ifdef ASCON_INV_SBOX_SELFCHECK_EN
  logic [LANES-1:0] lane_err;
  logic             err_reg, err_next;
`endif

  // Chunk columns are contiguous, so cnt + lane never wraps inside a chunk.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign col[gi]      = cnt_reg + 6'(gi);
      assign pre_col[gi]  = {work_reg[0][col[gi]], work_reg[1][col[gi]], work_reg[2][col[gi]],
                             work_reg[3][col[gi]], work_reg[4][col[gi]]};
      assign post_col[gi] = inv_sbox(pre_col[gi]);
`ifdef ASCON_INV_SBOX_SELFCHECK_EN
      assign lane_err[gi] = (fwd_sbox(post_col[gi]) != pre_col[gi]);
`endif
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      work_reg  <= '0;
      cnt_reg   <= '0;
`ifdef ASCON_INV_SBOX_SELFCHECK_EN
      err_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      work_reg  <= work_next;
      cnt_reg   <= cnt_next;
`ifdef ASCON_INV_SBOX_SELFCHECK_EN
      err_reg   <= err_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    work_next  = work_reg;
    cnt_next   = cnt_reg;
`ifdef ASCON_INV_SBOX_SELFCHECK_EN
    err_next   = err_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (in_valid_i) begin
          work_next  = state_array_i;
          cnt_next   = '0;
          state_next = BUSY;
`ifdef ASCON_INV_SBOX_SELFCHECK_EN
          err_next   = 1'b0;
`endif
        end
      end
      BUSY: begin
        for (int l = 0; l < LANES; l++) begin
          for (int w = 0; w < 5; w++) begin
            work_next[w][col[l]] = post_col[l][4-w];
          end
        end
        // For LANES=64 the 6-bit counter adds 0 and the single chunk is also the last.
        cnt_next = cnt_reg + LANES_W[5:0];
`ifdef ASCON_INV_SBOX_SELFCHECK_EN
        if (|lane_err) err_next = 1'b1;
`endif
        if (cnt_reg == LAST_CNT) state_next = DONE;
      end
      DONE: begin
        if (out_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready_o    = (state_reg == IDLE);
  assign out_valid_o   = (state_reg == DONE);
  assign state_array_o = work_reg;
`ifdef ASCON_INV_SBOX_SELFCHECK_EN
  assign err_o = err_reg;
`else
  assign err_o = 1'b0;
`endif

endmodule
